// File: rtl/adc_spi_capture.sv
// ---------------------------------------------------------------------------
// adc_spi_capture
//
// Serial ADC front-end for the scan FSM. A one-cycle trigger starts one SPI
// read frame (CS_n / SCLK / MISO) from an external serial ADC. The sample is
// returned with a one-cycle done pulse. Chip-select setup/hold time and the
// quiet time between conversions are enforced here.
//
// Parameters:
//   NB_ADC    sample width in bits (<= N_FRAME)
//   N_FRAME   SCLK periods per conversion frame
//   CLK_DIV   clk cycles per SCLK half-period, also CS setup/hold (>= 1)
//   QUIET_CYC clk cycles with CS_n high after a frame (>= 1)
//
// Ports:
//   clk            system clock
//   i_rst          asynchronous reset, active low
//   i_adc_trig     start-conversion pulse
//   o_adc_done     one-cycle pulse, o_adc_data valid from this cycle on
//   o_adc_data     last captured sample, held until the next done
//   o_busy         high from trigger acceptance through the end of QUIET
//   o_trig_overrun sticky: a trigger arrived while busy (cleared by reset)
//   o_cs_n         ADC chip select, active low
//   o_sclk         ADC serial clock, idles high
//   i_miso         ADC serial data, sampled as SCLK rises
// ---------------------------------------------------------------------------
module adc_spi_capture #(
  parameter int NB_ADC    = 12,
  parameter int N_FRAME   = 16,
  parameter int CLK_DIV   = 4,
  parameter int QUIET_CYC = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_adc_trig,
  output logic              o_adc_done,
  output logic [NB_ADC-1:0] o_adc_data,
  output logic              o_busy,
  output logic              o_trig_overrun,
  output logic              o_cs_n,
  output logic              o_sclk,
  input  logic              i_miso
);

  // One counter serves both the SCLK half-period / CS timing and QUIET.
  localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(N_FRAME + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N_FRAME - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE,
    QUIET
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               phase_q, phase_d;
  logic [NB_ADC-1:0]  shift_q, shift_d;
  logic [NB_ADC-1:0]  data_q, data_d;
  logic               overrun_q, overrun_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state logic. phase_q is 0 during the SCLK-low half of a bit and 1
  // during the high half. The shift register holds only the last NB_ADC bits
  // received: the leading N_FRAME-NB_ADC bits simply fall off the top, so
  // after the frame the register already equals the low NB_ADC bits of the
  // full frame. Output registers are computed from the next state so that
  // every output comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    data_d    = data_q;
    overrun_d = overrun_q | (i_adc_trig && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (i_adc_trig) begin
          state_d = CS_SETUP;
          cnt_d   = '0;
        end
      end

      CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            // SCLK rises at this edge: capture MISO now.
            phase_d = 1'b1;
            shift_d = (shift_q << 1) | NB_ADC'(i_miso);
          end else if (bit_q == BIT_LAST) begin
            state_d = CS_HOLD;
            phase_d = 1'b0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            phase_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          data_d  = shift_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The done cycle already has CS_n high; QUIET_CYC further cycles
      // follow before a trigger is accepted again.
      DONE: begin
        state_d = QUIET;
        cnt_d   = '0;
      end

      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
    sclk_d = !((state_d == SHIFT) && !phase_d);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers. Reset aborts any frame in progress and
  // discards the partial sample.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_adc_done     = done_q;
  assign o_adc_data     = data_q;
  assign o_busy         = busy_q;
  assign o_trig_overrun = overrun_q;
  assign o_cs_n         = cs_n_q;
  assign o_sclk         = sclk_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_capture
//
// Two instances: dutA with default parameters and dutB with CLK_DIV=1,
// N_FRAME=12. Each has a small serial ADC model. Expected samples and their
// done cycles are queued when a trigger is issued; a monitor per instance
// pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_adc_spi_capture;

  typedef struct {
    logic [11:0] data;
    int          cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        trigA, trigB, misoA, misoB;
  logic        doneA, doneB, busyA, busyB, ovrA, ovrB;
  logic        csnA, csnB, sclkA, sclkB;
  logic [11:0] dataA, dataB;

  logic [15:0] frameA = 16'h0;
  logic [11:0] frameB = 12'h0;
  int          idxA = -1;
  int          idxB = -1;

  exp_t expA[$];
  exp_t expB[$];
  int   risesA[$];
  int   csFallA = -1;
  logic prevSclkA = 1'b1;
  logic prevCsnA  = 1'b1;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCnt    = 0;

  // 10-unit clock period and a free-running cycle number
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  adc_spi_capture dutA (
    .clk           (clk),
    .i_rst         (rstN),
    .i_adc_trig    (trigA),
    .o_adc_done    (doneA),
    .o_adc_data    (dataA),
    .o_busy        (busyA),
    .o_trig_overrun(ovrA),
    .o_cs_n        (csnA),
    .o_sclk        (sclkA),
    .i_miso        (misoA)
  );

  adc_spi_capture #(
    .NB_ADC   (12),
    .N_FRAME  (12),
    .CLK_DIV  (1),
    .QUIET_CYC(8)
  ) dutB (
    .clk           (clk),
    .i_rst         (rstN),
    .i_adc_trig    (trigB),
    .o_adc_done    (doneB),
    .o_adc_data    (dataB),
    .o_busy        (busyB),
    .o_trig_overrun(ovrB),
    .o_cs_n        (csnB),
    .o_sclk        (sclkB),
    .i_miso        (misoB)
  );

  // ADC model A: the MSB is presented first; each SCLK falling edge
  // presents the next bit, so it is stable at the following rising edge.
  always @(negedge csnA) idxA = 15;

  always @(negedge sclkA) begin
    if (csnA === 1'b0 && idxA >= 0) begin
      misoA = frameA[idxA];
      idxA  = idxA - 1;
    end
  end

  // ADC model B: same behaviour for the 12-bit frame
  always @(negedge csnB) idxB = 11;

  always @(negedge sclkB) begin
    if (csnB === 1'b0 && idxB >= 0) begin
      misoB = frameB[idxB];
      idxB  = idxB - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Must be called at a negedge; drives a one-cycle trigger and reports the
  // cycle number T in which the trigger was presented.
  task automatic applyStimulus(input bit useB, input logic [15:0] frame,
                               output int t);
    if (useB) begin
      frameB = frame[11:0];
      trigB  = 1'b1;
    end else begin
      frameA = frame;
      trigA  = 1'b1;
    end
    t = cycleCnt;
    @(negedge clk);
    trigA = 1'b0;
    trigB = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    do @(negedge clk); while (cycleCnt < c);
  endtask

  // Scoreboard monitor for dutA
  always @(negedge clk) begin
    exp_t e;
    if (doneA === 1'b1) begin
      if (expA.size() == 0) begin
        checkOutput("A unexpected done", {31'b0, doneA}, 32'd0);
      end else begin
        e = expA.pop_front();
        checkOutput("A sample", {20'b0, dataA}, {20'b0, e.data});
        checkOutput("A done cycle", cycleCnt, e.cycle);
      end
    end
  end

  // Scoreboard monitor for dutB
  always @(negedge clk) begin
    exp_t e;
    if (doneB === 1'b1) begin
      if (expB.size() == 0) begin
        checkOutput("B unexpected done", {31'b0, doneB}, 32'd0);
      end else begin
        e = expB.pop_front();
        checkOutput("B sample", {20'b0, dataB}, {20'b0, e.data});
        checkOutput("B done cycle", cycleCnt, e.cycle);
      end
    end
  end

  // Records SCLK rising edges and the CS_n falling edge of dutA
  always @(negedge clk) begin
    if (prevSclkA === 1'b0 && sclkA === 1'b1 && csnA === 1'b0)
      risesA.push_back(cycleCnt);
    if (prevCsnA === 1'b1 && csnA === 1'b0)
      csFallA = cycleCnt;
    prevSclkA <= sclkA;
    prevCsnA  <= csnA;
  end

  // Directed test sequence
  initial begin
    int t;
    int t2;
    int bad;

    rstN  = 1'b0;
    trigA = 1'b0;
    trigB = 1'b0;
    misoA = 1'b0;
    misoB = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    // Idle after reset
    repeat (20) begin
      @(negedge clk);
      checkOutput("idle outputs", {16'b0, csnA, sclkA, busyA, doneA, dataA},
                  {16'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
    end

    // Single frame, full timing
    risesA.delete();
    applyStimulus(1'b0, 16'h0ABC, t);
    expA.push_back('{data: 12'hABC, cycle: t + 137});
    waitUntil(t + 145);
    checkOutput("busy in quiet", {31'b0, busyA}, 32'd1);
    waitUntil(t + 146);
    checkOutput("busy falls", {31'b0, busyA}, 32'd0);
    checkOutput("cs_n fall cycle", csFallA, t + 1);
    checkOutput("sclk rise count", risesA.size(), 16);
    checkOutput("first sclk rise", (risesA.size() > 0) ? risesA[0] : -1, t + 9);
    bad = 0;
    for (int i = 1; i < risesA.size(); i++)
      if (risesA[i] - risesA[i-1] != 8) bad++;
    checkOutput("sclk rise spacing", bad, 0);

    // Back-to-back frames, second trigger in the first IDLE cycle
    applyStimulus(1'b0, 16'hFFFF, t);
    expA.push_back('{data: 12'hFFF, cycle: t + 137});
    waitUntil(t + 146);
    applyStimulus(1'b0, 16'h0001, t2);
    expA.push_back('{data: 12'h001, cycle: t2 + 137});
    waitUntil(t2 + 146);
    checkOutput("no overrun b2b", {31'b0, ovrA}, 32'd0);
    checkOutput("b2b queue drained", expA.size(), 0);

    // Triggers during SHIFT and QUIET are ignored and flag overrun
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 16'hF123, t);
    expA.push_back('{data: 12'h123, cycle: t + 137});
    waitUntil(t + 50);
    trigA = 1'b1;
    @(negedge clk);
    trigA = 1'b0;
    checkOutput("overrun set", {31'b0, ovrA}, 32'd1);
    waitUntil(t + 140);
    trigA = 1'b1;
    @(negedge clk);
    trigA = 1'b0;
    waitUntil(t + 200);
    checkOutput("overrun held", {31'b0, ovrA}, 32'd1);
    checkOutput("single done queue", expA.size(), 0);
    checkOutput("idle after ignored", {31'b0, busyA}, 32'd0);

    // Reset mid-frame aborts without a done
    applyStimulus(1'b0, 16'h0FFF, t);
    waitUntil(t + 70);
    checkOutput("sclk low before reset", {31'b0, sclkA}, 32'd0);
    rstN = 1'b0;
    #1;
    checkOutput("reset cs_n/sclk/busy/ovr", {28'b0, csnA, sclkA, busyA, ovrA},
                {28'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    waitUntil(t + 73);
    rstN = 1'b1;
    waitUntil(t + 200);
    checkOutput("data kept at reset value", {20'b0, dataA}, 32'h0);
    applyStimulus(1'b0, 16'h0555, t);
    expA.push_back('{data: 12'h555, cycle: t + 137});
    waitUntil(t + 146);
    checkOutput("post-reset queue", expA.size(), 0);

    // Fast instance: CLK_DIV=1, N_FRAME=12
    applyStimulus(1'b1, 16'h08F1, t);
    expB.push_back('{data: 12'h8F1, cycle: t + 27});
    waitUntil(t + 40);
    checkOutput("B queue drained", expB.size(), 0);
    checkOutput("B idle", {31'b0, busyB}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Serial ADC front-end that services the scan FSM's ADC handshake.
- A one-cycle trigger from the scan FSM starts one SPI read frame from an external serial ADC (CS_n/SCLK/MISO, 16-bit frame, data MSB-first in the last NB_ADC bits).
- Returns the sample with a one-cycle done pulse, which the scan FSM uses to write RAM.
- Enforces chip-select setup/hold and inter-conversion quiet time.

Parameters:
- NB_ADC, 12, sample width in bits; must be <= N_FRAME.
- N_FRAME, 16, SCLK periods per conversion frame.
- CLK_DIV, 4, clk cycles per SCLK half-period; also CS setup and CS hold length in clk cycles; must be >= 1.
- QUIET_CYC, 8, clk cycles with CS_n high after a frame before a new trigger is accepted; must be >= 1.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_adc_trig  in  1  start-conversion pulse from the scan FSM.
- o_adc_done  out  1  one-cycle pulse; o_adc_data is valid from this cycle on.
- o_adc_data  out  NB_ADC  last captured sample; held until the next done.
- o_busy  out  1  high from trigger acceptance through the end of QUIET.
- o_trig_overrun  out  1  sticky flag: a trigger arrived while busy; cleared only by reset.
- o_cs_n  out  1  ADC chip select, active low.
- o_sclk  out  1  ADC serial clock; idles high.
- i_miso  in  1  ADC serial data; must be stable at SCLK rising edges.

Behaviour:
- Reset (i_rst low, async): state IDLE, o_cs_n=1, o_sclk=1, o_adc_done=0, o_adc_data=0, o_busy=0, o_trig_overrun=0, all counters and the shift register = 0. A reset asserted mid-frame aborts immediately; the partial sample is discarded and no done is issued.
- IDLE:
  - i_adc_trig=1 at cycle T -> CS_SETUP at T+1.
  - o_cs_n=0 and o_busy=1 from T+1.
- CS_SETUP: CLK_DIV cycles with o_sclk=1, then SHIFT.
- SHIFT: N_FRAME bit periods. Each period is CLK_DIV cycles with o_sclk=0, then CLK_DIV cycles with o_sclk=1.
  - i_miso is sampled on the clk edge at which o_sclk rises to 1.
  - The bit shifts into an N_FRAME-bit register, MSB first.
  - A bit counter counts 0..N_FRAME-1; after the high phase of the last bit -> CS_HOLD.
- CS_HOLD: CLK_DIV cycles with o_sclk=1 and o_cs_n=0. On exit:
  - o_cs_n=1;
  - o_adc_data = low NB_ADC bits of the shift register;
  - o_adc_done=1 for exactly that cycle.
- QUIET: QUIET_CYC cycles with o_cs_n=1 and o_busy=1, then IDLE with o_busy=0.
- Latency: done rises at T+1+CLK_DIV*(2*N_FRAME+2). With defaults this is T+137.
- Next accepted trigger: the earliest is the first IDLE cycle, done cycle + QUIET_CYC + 1 (defaults: T+146).
- Trigger in any state other than IDLE: ignored (no effect on the frame in progress); o_trig_overrun set to 1.
- Trigger in the same cycle the FSM re-enters IDLE: accepted.
- Leading N_FRAME-NB_ADC bits are discarded and not checked.
- o_adc_data changes only in done cycles.
- All outputs are registered; no combinational path from i_miso or i_adc_trig to any output.

Test Plan:
- Reset, then idle for 20 cycles -> o_cs_n=1, o_sclk=1, o_busy=0, o_adc_done=0, o_adc_data=0 throughout.
- Defaults; trigger at T; ADC model drives frame 16'h0ABC -> o_cs_n falls at T+1; 16 SCLK rising edges, each 8 cycles apart with the first at T+9; done at T+137 with o_adc_data=12'hABC; o_busy falls at T+146.
- ADC model drives 16'hFFFF, then a second trigger at the first IDLE cycle with 16'h0001 -> first done gives 12'hFFF; second trigger is accepted (no overrun); second done gives 12'h001.
- Triggers at T+50 and at T+140 (QUIET) -> both ignored; exactly one done; o_trig_overrun=1 and held.
- i_rst asserted low at T+70 -> o_cs_n=1 and o_sclk=1 immediately; no done. After release, a new trigger with frame 16'h0555 gives 12'h555.
- CLK_DIV=1, N_FRAME=12, NB_ADC=12; trigger at T with frame 12'h8F1 -> done at T+27 with o_adc_data=12'h8F1.
